legv8_cache_tag_ctrl: RTL and testbench
=======================================

Name: legv8_cache_tag_ctrl

Overview:
Parametrised, clocked N-way set-associative tag store and miss controller for the LEGv8 data path. It is the successor to the single-set, combinational tag check. Block data is excluded for simulation, as before; the block tracks only valid bits and tags. It accepts lookups through a ready/valid handshake, reports hit or miss and the way used, fetches on a miss through a req/ack handshake to the memory model, fills a victim way, and supports a whole-cache flush.

Parameters:
ADDR_W, 64, byte address width.
INDEX_W, 4, set index bits; SETS = 2**INDEX_W.
OFFSET_W, 3, block offset bits (8-byte blocks).
WAYS, 2, associativity; must be a power of 2 and at least 2; WAY_W = clog2(WAYS).
Derived: TAG_W = ADDR_W - INDEX_W - OFFSET_W (57 with the defaults).

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  lookup request.
req_ready  out  1  combinational: (state==IDLE) && !flush_pending && !flush.
req_addr  in  ADDR_W  lookup address; index = [OFFSET_W+INDEX_W-1:OFFSET_W], tag = [ADDR_W-1:OFFSET_W+INDEX_W].
flush  in  1  level request to invalidate all lines.
resp_valid  out  1  registered one-cycle pulse.
resp_hit  out  1  1 = hit, 0 = miss then fill.
resp_way  out  WAY_W  way that hit or was filled.
mem_req  out  1  block fetch request, held until acked.
mem_addr  out  ADDR_W  captured address with offset bits zeroed.
mem_ack  in  1  fetch complete.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Storage per set: WAYS entries of {valid, tag[TAG_W-1:0]}, plus a WAY_W round-robin victim pointer per set.
- Reset (asynchronous): all valid bits = 0; all pointers = 0; state = IDLE; flush_pending = 0. Outputs resp_valid, resp_hit, resp_way, mem_req, mem_addr and busy all = 0. req_ready = 1 once rst deasserts.
- A lookup is accepted on the edge where req_valid && req_ready. req_addr is captured and the state goes IDLE->LOOKUP.
- LOOKUP (1 cycle): compare the captured tag against every valid way of the indexed set.
  - Hit: next edge sets resp_valid=1, resp_hit=1, resp_way = matching way; state -> IDLE. Hit latency is 2 edges from acceptance.
  - More than one way matching is illegal; if it occurs, the lowest way index is reported.
  - Miss: next edge goes to MISS with mem_req=1 and mem_addr = {tag, index, OFFSET_W'b0}.
- MISS: mem_req is held high until mem_ack is sampled high. mem_ack high in the first MISS cycle is legal. On the ack edge:
  - Victim = lowest-index invalid way in the set; if all ways are valid, the set's pointer.
  - Write {1, tag} into the victim way.
  - If the set was full, pointer = pointer+1 modulo WAYS; otherwise the pointer is unchanged.
  - mem_req=0; resp_valid=1, resp_hit=0, resp_way = victim; state -> IDLE.
- resp_valid is high only in the first IDLE cycle after LOOKUP or MISS. A new request may be accepted in that same cycle, so back-to-back hits give one response every 2 cycles.
- flush:
  - Sampled every cycle and latched into flush_pending.
  - In IDLE, a pending or present flush has priority over req_valid, and the request is not accepted.
  - IDLE->FLUSH: one set is cleared per cycle (all ways' valid bits = 0, pointer = 0), from set 0 to set SETS-1. This takes exactly SETS cycles, then state -> IDLE and flush_pending is cleared.
  - A flush raised during LOOKUP or MISS waits until that operation completes and its response is issued.
- Reset mid-operation (any state): immediate abort. mem_req drops asynchronously, no install occurs, and no response is issued.
- Tags and valid bits are never modified except by a fill, a flush or a reset.

Test Plan:
- After reset, request 0x1008 (index 1, tag 0x20) -> mem_req=1 with mem_addr=0x1008; mem_ack after 3 cycles -> resp_valid pulse, resp_hit=0, resp_way=0. Repeat 0x1008 -> resp_hit=1, resp_way=0, resp_valid 2 edges after acceptance.
- Fill 0x2008 (tag 0x40) -> way 1 (invalid way first). Request 0x3008 (tag 0x60) -> victim way 0, pointer becomes 1. Then 0x1008 misses, and 0x2008 hits in way 1.
- Assert flush for 1 cycle with valid lines present -> busy high for exactly 16 cycles, req_ready=0 throughout. Afterwards 0x2008 misses and fills way 0.
- Raise flush while in MISS -> the miss completes with a response first, then 16 FLUSH cycles; a req_valid held throughout is accepted only after the flush.
- Assert rst while mem_req=1 -> mem_req=0 immediately, no resp_valid. After release, the same address misses.
- mem_ack high in the first MISS cycle -> exactly one fill and one response; back-to-back hit requests give one resp_valid every 2 cycles.

Source files
------------

// File: rtl/legv8_cache_tag_ctrl.sv
// N-way set-associative tag store and miss controller for the LEGv8 data path.
// Holds valid bits and tags only; block data stays in the memory model.
module legv8_cache_tag_ctrl #(
  parameter int  ADDR_W   = 64,
  parameter int  INDEX_W  = 4,
  parameter int  OFFSET_W = 3,
  parameter int  WAYS     = 2,
  localparam int WAY_W    = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              busy
);

  localparam int SETS  = 2 ** INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, FLUSH} state_e;

  state_e                     state_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [SETS-1:0][WAYS-1:0]  valid_q;
  logic [SETS-1:0][WAY_W-1:0] ptr_q;
  logic [TAG_W-1:0]           tag_mem_q [SETS][WAYS];
  logic                       flush_pending_q;
  logic [INDEX_W-1:0]         flush_idx_q;
  logic                       resp_valid_q;
  logic                       resp_hit_q;
  logic [WAY_W-1:0]           resp_way_q;
  logic                       mem_req_q;
  logic [ADDR_W-1:0]          mem_addr_q;

  logic [TAG_W-1:0]   cur_tag;
  logic [INDEX_W-1:0] cur_idx;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   victim;
  logic               set_full;

  assign cur_tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign cur_idx  = addr_q[OFFSET_W +: INDEX_W];
  assign set_full = &valid_q[cur_idx];

  // Walking from the top way down lets the lowest matching / invalid way win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hit     = 1'b0;
    hit_way = '0;
    victim  = ptr_q[cur_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[cur_idx][w] && (tag_mem_q[cur_idx][w] == cur_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[cur_idx][w]) begin
        victim = WAY_W'(w);
      end
    end
  end

  // NOTE: the tag array has no reset; valid bits alone decide whether a tag means anything.
  always_ff @(posedge clk) begin
    if (state_q == MISS && mem_ack) begin
      tag_mem_q[cur_idx][victim] <= cur_tag;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      valid_q         <= '0;
      ptr_q           <= '0;
      flush_pending_q <= 1'b0;
      flush_idx_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_way_q      <= '0;
      mem_req_q       <= 1'b0;
      mem_addr_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if (flush) begin
        flush_pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (flush || flush_pending_q) begin
            state_q     <= FLUSH;
            flush_idx_q <= '0;
          end else if (req_valid) begin
            addr_q  <= req_addr;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_way_q   <= hit_way;
            state_q      <= IDLE;
          end else begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= addr_q & ~OFFSET_MASK;
            state_q    <= MISS;
          end
        end
        MISS: begin
          if (mem_ack) begin
            valid_q[cur_idx][victim] <= 1'b1;
            // Round-robin only advances when an existing line had to be evicted.
            if (set_full) begin
              ptr_q[cur_idx] <= ptr_q[cur_idx] + WAY_W'(1);
            end
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= victim;
            state_q      <= IDLE;
          end
        end
        FLUSH: begin
          valid_q[flush_idx_q] <= '0;
          ptr_q[flush_idx_q]   <= '0;
          flush_idx_q          <= flush_idx_q + INDEX_W'(1);
          if (flush_idx_q == INDEX_W'(SETS - 1)) begin
            state_q         <= IDLE;
            flush_pending_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !flush_pending_q && !flush;
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_way   = resp_way_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_legv8_cache_tag_ctrl.sv
// Self-checking bench for legv8_cache_tag_ctrl: directed scenarios plus random
// lookups against a set/way/pointer model kept as plain arrays.
module tb_legv8_cache_tag_ctrl;

  localparam int ADDR_W   = 64;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 3;
  localparam int WAYS     = 2;
  localparam int WAY_W    = $clog2(WAYS);
  localparam int SETS     = 2 ** INDEX_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              flush;
  logic              resp_valid;
  logic              resp_hit;
  logic [WAY_W-1:0]  resp_way;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              busy;

  legv8_cache_tag_ctrl #(
    .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .WAYS(WAYS)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] way;
  } exp_t;

  exp_t        exp_q [$];
  logic        exp_mreq;
  logic [63:0] exp_maddr;

  bit          m_valid [SETS][WAYS];
  logic [63:0] m_tag   [SETS][WAYS];
  int          m_ptr   [SETS];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    end
  endfunction

  function automatic bit model_lookup(input logic [63:0] a, output int way);
    int          idx = int'((a >> OFFSET_W) % SETS);
    logic [63:0] tag = a >> (OFFSET_W + INDEX_W);
    way = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (m_valid[idx][w] && m_tag[idx][w] == tag) begin
        way = w;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int model_fill(input logic [63:0] a);
    int          idx = int'((a >> OFFSET_W) % SETS);
    logic [63:0] tag = a >> (OFFSET_W + INDEX_W);
    int          v   = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (!m_valid[idx][w] && v < 0) v = w;
    end
    if (v < 0) begin
      v = m_ptr[idx];
      m_ptr[idx] = (m_ptr[idx] + 1) % WAYS;
    end
    m_valid[idx][v] = 1'b1;
    m_tag[idx][v]   = tag;
    return v;
  endfunction

  // Per-cycle comparison of the memory interface and every response pulse.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      check("mem_req", 64'(mem_req), 64'(exp_mreq));
      if (mem_req) check("mem_addr", mem_addr, exp_maddr);
      if (resp_valid) begin
        check("resp_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("resp_hit", 64'(resp_hit), 64'(e.hit));
          check("resp_way", 64'(resp_way), 64'(e.way));
        end
      end
    end
  end

  task automatic lookup(input logic [63:0] a, input int ack_dly,
                        output logic got_hit, output logic [WAY_W-1:0] got_way,
                        output logic [63:0] got_maddr);
    int   n;
    int   p_way;
    int   v;
    bit   p_hit;
    exp_t e;
    req_valid = 1'b1;
    req_addr  = a;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 64'(req_ready), 64'd1);
    p_hit     = model_lookup(a, p_way);
    exp_maddr = (a >> OFFSET_W) << OFFSET_W;
    if (p_hit) begin
      e.hit = 1'b1;
      e.way = WAY_W'(p_way);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("accept_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    got_maddr = mem_addr;
    if (p_hit) begin
      check("hit_latency", 64'(resp_valid), 64'd1);
    end else begin
      exp_mreq = 1'b1;
      check("miss_req", 64'(mem_req), 64'd1);
      for (int i = 0; i < ack_dly; i++) begin
        @(posedge clk); #1;
      end
      mem_ack = 1'b1;
      v = model_fill(a);
      e.hit = 1'b0;
      e.way = WAY_W'(v);
      exp_q.push_back(e);
      @(posedge clk); #1;
      mem_ack  = 1'b0;
      exp_mreq = 1'b0;
      check("miss_resp", 64'(resp_valid), 64'd1);
      check("miss_req_drop", 64'(mem_req), 64'd0);
    end
    got_hit = resp_hit;
    got_way = resp_way;
  endtask

  task automatic flush_cycles(input string tag);
    for (int i = 0; i < SETS; i++) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_ready"}, 64'(req_ready), 64'd0);
      @(posedge clk); #1;
    end
    check({tag, "_done"}, 64'(busy), 64'd0);
    model_clear();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    #1;
    check("flush_blocks_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    flush_cycles("flush");
    check("flush_ready_after", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic             h;
    logic [WAY_W-1:0] w;
    logic [63:0]      ma;
    logic [63:0]      a;
    exp_t             e;
    int               p_way;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; mem_ack = 1'b0;
    exp_mreq = 1'b0; exp_maddr = '0;
    model_clear();
    #12;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_hit", 64'(resp_hit), 64'd0);
    check("rst_resp_way", 64'(resp_way), 64'd0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);

    // First miss then hit of the same block.
    lookup(64'h1008, 3, h, w, ma);
    check("p1_miss", 64'(h), 64'd0);
    check("p1_way", 64'(w), 64'd0);
    check("p1_mem_addr", ma, 64'h1008);
    lookup(64'h1008, 0, h, w, ma);
    check("p1_hit", 64'(h), 64'd1);
    check("p1_hit_way", 64'(w), 64'd0);

    // Invalid way filled first, then round-robin eviction.
    lookup(64'h2008, 1, h, w, ma);
    check("p2_fill_way", 64'(w), 64'd1);
    lookup(64'h300D, 2, h, w, ma);
    check("p2_evict_miss", 64'(h), 64'd0);
    check("p2_evict_way", 64'(w), 64'd0);
    check("p2_evict_maddr", ma, 64'h3008);
    lookup(64'h2008, 0, h, w, ma);
    check("p2_hit2008", 64'(h), 64'd1);
    check("p2_hit2008_way", 64'(w), 64'd1);
    lookup(64'h1008, 1, h, w, ma);
    check("p2_1008_miss", 64'(h), 64'd0);
    check("p2_1008_way", 64'(w), 64'd1);

    // Flush wipes everything.
    do_flush();
    lookup(64'h2008, 1, h, w, ma);
    check("p3_post_flush_miss", 64'(h), 64'd0);
    check("p3_post_flush_way", 64'(w), 64'd0);

    // Flush raised during MISS waits for the response; held request waits for the flush.
    check("fm_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = 64'h4010;
    exp_maddr = 64'h4010;
    @(posedge clk); #1;
    req_addr = 64'h2008;
    @(posedge clk); #1;
    exp_mreq = 1'b1;
    check("fm_mem_req", 64'(mem_req), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    mem_ack = 1'b1;
    e.hit = 1'b0;
    e.way = WAY_W'(model_fill(64'h4010));
    exp_q.push_back(e);
    @(posedge clk); #1;
    mem_ack  = 1'b0;
    exp_mreq = 1'b0;
    check("fm_resp_first", 64'(resp_valid), 64'd1);
    check("fm_resp_way", 64'(resp_way), 64'd0);
    check("fm_ready_pending", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush_cycles("fm_flush");
    lookup(64'h2008, 0, h, w, ma);
    check("fm_after_miss", 64'(h), 64'd0);

    // Reset while a fetch is outstanding.
    req_valid = 1'b1;
    req_addr  = 64'h5018;
    exp_maddr = 64'h5018;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    exp_mreq = 1'b1;
    check("rm_mem_req", 64'(mem_req), 64'd1);
    @(posedge clk); #3;
    exp_mreq = 1'b0;
    rst = 1'b1;
    #1;
    check("rm_mem_req_async", 64'(mem_req), 64'd0);
    check("rm_busy", 64'(busy), 64'd0);
    check("rm_no_resp", 64'(resp_valid), 64'd0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lookup(64'h5018, 2, h, w, ma);
    check("rm_same_addr_miss", 64'(h), 64'd0);
    check("rm_same_addr_way", 64'(w), 64'd0);

    // Ack in the first MISS cycle, then back-to-back hits.
    lookup(64'h6020, 0, h, w, ma);
    check("ack0_miss", 64'(h), 64'd0);
    check("ack0_way", 64'(w), 64'd0);
    req_valid = 1'b1;
    req_addr  = 64'h6027;
    for (int k = 0; k < 4; k++) begin
      e.hit = model_lookup(64'h6027, p_way);
      e.way = WAY_W'(p_way);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 6) req_valid = 1'b0;
      check($sformatf("b2b_%0d", i), 64'(resp_valid), 64'(i % 2));
    end

    // Random traffic over a few sets and a small tag pool to force hits and evictions.
    for (int t = 0; t < 80; t++) begin
      int k   = int'($urandom_range(0, 5));
      int idx = int'($urandom_range(0, 3));
      int off = int'($urandom_range(0, 7));
      logic [63:0] tagv = (64'(k) << 40) | 64'(k + 1);
      a = (tagv << (OFFSET_W + INDEX_W)) | (64'(idx) << OFFSET_W) | 64'(off);
      if ($urandom_range(0, 11) == 0) do_flush();
      lookup(a, int'($urandom_range(0, 3)), h, w, ma);
    end

    @(posedge clk); #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
